// File: rtl/mem_agu_station_if.sv
// Bus bundle between the memory reservation station / AGU and its
// neighbours: dispatch, the result broadcast (CDB), the register file read
// ports and the address result to the memory queue.
//   slave  : the station's view (dispatch/cdb/rf data in; full, rf addr, result out)
//   master : the surrounding pipeline's view (mirror of slave)
interface mem_agu_station_if #(
  parameter int PREG_W = 6,
  parameter int IDX_W  = 6,
  parameter int ROB_W  = 6
);
  logic              flush;
  logic              disp_valid;
  logic [6:0]        disp_opcode;
  logic [31:0]       disp_imm;
  logic [PREG_W-1:0] disp_ps1;
  logic              disp_ps1_ready;
  logic [PREG_W-1:0] disp_ps2;
  logic              disp_ps2_ready;
  logic [IDX_W-1:0]  disp_mem_idx;
  logic [ROB_W-1:0]  disp_rob_num;
  logic              full;
  logic              cdb_valid;
  logic [PREG_W-1:0] cdb_pd;
  logic [PREG_W-1:0] rf_ps1;
  logic [PREG_W-1:0] rf_ps2;
  logic [31:0]       rf_ps1_data;
  logic [31:0]       rf_ps2_data;
  logic              addr_valid;
  logic [31:0]       addr;
  logic [IDX_W-1:0]  mem_idx_out;
  logic [31:0]       store_wdata;
  logic [ROB_W-1:0]  rob_num_out;

  modport slave (
    input  flush, disp_valid, disp_opcode, disp_imm, disp_ps1, disp_ps1_ready,
           disp_ps2, disp_ps2_ready, disp_mem_idx, disp_rob_num,
           cdb_valid, cdb_pd, rf_ps1_data, rf_ps2_data,
    output full, rf_ps1, rf_ps2, addr_valid, addr, mem_idx_out, store_wdata,
           rob_num_out
  );

  modport master (
    output flush, disp_valid, disp_opcode, disp_imm, disp_ps1, disp_ps1_ready,
           disp_ps2, disp_ps2_ready, disp_mem_idx, disp_rob_num,
           cdb_valid, cdb_pd, rf_ps1_data, rf_ps2_data,
    input  full, rf_ps1, rf_ps2, addr_valid, addr, mem_idx_out, store_wdata,
           rob_num_out
  );
endinterface

// File: rtl/mem_agu_station.sv
// Reservation station + address generation for loads and stores.
// Holds dispatched memory ops until both physical sources are ready, picks
// the lowest-index ready entry each cycle, reads the register file through
// rf_ps1/rf_ps2 and registers addr = rs1 + imm plus store data one cycle later.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mem_agu_station_if.slave (dispatch, cdb, rf read, result, flush)
module mem_agu_station #(
  parameter int DEPTH  = 8,
  parameter int PREG_W = 6,
  parameter int IDX_W  = 6,
  parameter int ROB_W  = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_agu_station_if.slave   bus
);

  localparam int         SEL_W    = $clog2(DEPTH);
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic [DEPTH-1:0]  e_valid;
  logic [DEPTH-1:0]  e_store;
  logic [DEPTH-1:0]  e_r1;
  logic [DEPTH-1:0]  e_r2;
  logic [31:0]       e_imm     [DEPTH];
  logic [PREG_W-1:0] e_ps1     [DEPTH];
  logic [PREG_W-1:0] e_ps2     [DEPTH];
  logic [IDX_W-1:0]  e_mem_idx [DEPTH];
  logic [ROB_W-1:0]  e_rob     [DEPTH];

  logic [DEPTH-1:0]  eligible;
  logic              sel_found;
  logic [SEL_W-1:0]  sel_idx;
  logic              free_found;
  logic [SEL_W-1:0]  free_idx;
  logic              disp_take;
  logic              cdb_hit;
  logic              disp_is_store;
  logic              disp_r1;
  logic              disp_r2;

  // Selection only looks at registered ready bits, so a wakeup is always
  // seen one cycle later.
  assign eligible = e_valid & e_r1 & e_r2;

  // Scan downwards so the lowest index wins.
  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel_found = 1'b1;
        sel_idx   = SEL_W'(i);
      end
      if (!e_valid[i]) begin
        free_found = 1'b1;
        free_idx   = SEL_W'(i);
      end
    end
  end

  // The entry being issued is still valid here, so it can't be reused
  // by dispatch until the next cycle.
  assign bus.full = &e_valid;
  assign disp_take = bus.disp_valid && free_found;

  // Register 0 is hard-wired ready and never produced by the CDB.
  assign cdb_hit       = bus.cdb_valid && (bus.cdb_pd != '0);
  assign disp_is_store = (bus.disp_opcode == OP_STORE);
  assign disp_r1 = bus.disp_ps1_ready || (bus.disp_ps1 == '0) ||
                   (cdb_hit && (bus.cdb_pd == bus.disp_ps1));
  assign disp_r2 = !disp_is_store || bus.disp_ps2_ready || (bus.disp_ps2 == '0) ||
                   (cdb_hit && (bus.cdb_pd == bus.disp_ps2));

  assign bus.rf_ps1 = sel_found ? e_ps1[sel_idx] : '0;
  assign bus.rf_ps2 = sel_found ? e_ps2[sel_idx] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid <= '0;
      e_store <= '0;
      e_r1    <= '0;
      e_r2    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_imm[i]     <= '0;
        e_ps1[i]     <= '0;
        e_ps2[i]     <= '0;
        e_mem_idx[i] <= '0;
        e_rob[i]     <= '0;
      end
    end else if (bus.flush) begin
      e_valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (e_valid[i] && cdb_hit) begin
          if (e_ps1[i] == bus.cdb_pd) e_r1[i] <= 1'b1;
          if (e_ps2[i] == bus.cdb_pd) e_r2[i] <= 1'b1;
        end
        if (sel_found && (sel_idx == SEL_W'(i))) begin
          e_valid[i] <= 1'b0;
        end
        // free_idx and sel_idx never coincide (free is invalid, sel is valid).
        if (disp_take && (free_idx == SEL_W'(i))) begin
          e_valid[i]   <= 1'b1;
          e_store[i]   <= disp_is_store;
          e_r1[i]      <= disp_r1;
          e_r2[i]      <= disp_r2;
          e_imm[i]     <= bus.disp_imm;
          e_ps1[i]     <= bus.disp_ps1;
          e_ps2[i]     <= bus.disp_ps2;
          e_mem_idx[i] <= bus.disp_mem_idx;
          e_rob[i]     <= bus.disp_rob_num;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.addr_valid  <= 1'b0;
      bus.addr        <= '0;
      bus.mem_idx_out <= '0;
      bus.store_wdata <= '0;
      bus.rob_num_out <= '0;
    end else begin
      bus.addr_valid <= sel_found && !bus.flush;
      if (sel_found && !bus.flush) begin
        bus.addr        <= bus.rf_ps1_data + e_imm[sel_idx];
        bus.store_wdata <= e_store[sel_idx] ? bus.rf_ps2_data : 32'd0;
        bus.mem_idx_out <= e_mem_idx[sel_idx];
        bus.rob_num_out <= e_rob[sel_idx];
      end
    end
  end

endmodule

// File: tb/tb_mem_agu_station.sv
module tb_mem_agu_station;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;
  logic [31:0] rf [64];

  mem_agu_station_if #(.PREG_W(6), .IDX_W(6), .ROB_W(6)) agu_if ();

  mem_agu_station #(.DEPTH(8), .PREG_W(6), .IDX_W(6), .ROB_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (agu_if)
  );

  assign agu_if.rf_ps1_data = rf[agu_if.rf_ps1];
  assign agu_if.rf_ps2_data = rf[agu_if.rf_ps2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    agu_if.disp_valid = 1'b0;
    agu_if.cdb_valid  = 1'b0;
    agu_if.cdb_pd     = '0;
    agu_if.flush      = 1'b0;
  endtask

  task automatic set_disp(input logic [6:0] op, input logic [31:0] imm,
                          input logic [5:0] ps1, input logic r1,
                          input logic [5:0] ps2, input logic r2,
                          input logic [5:0] idx, input logic [5:0] rob);
    agu_if.disp_valid     = 1'b1;
    agu_if.disp_opcode    = op;
    agu_if.disp_imm       = imm;
    agu_if.disp_ps1       = ps1;
    agu_if.disp_ps1_ready = r1;
    agu_if.disp_ps2       = ps2;
    agu_if.disp_ps2_ready = r2;
    agu_if.disp_mem_idx   = idx;
    agu_if.disp_rob_num   = rob;
  endtask

  task automatic chk_result(input string tag, input logic [31:0] a,
                            input logic [5:0] idx, input logic [31:0] wd,
                            input logic [5:0] rob);
    chk({tag, "_valid"}, 32'(agu_if.addr_valid), 32'd1);
    chk({tag, "_addr"},  agu_if.addr, a);
    chk({tag, "_idx"},   32'(agu_if.mem_idx_out), 32'(idx));
    chk({tag, "_wdata"}, agu_if.store_wdata, wd);
    chk({tag, "_rob"},   32'(agu_if.rob_num_out), 32'(rob));
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    for (int i = 0; i < 64; i++) rf[i] = 32'h0;
    rf[5]  = 32'h0000_1000;
    rf[7]  = 32'h0000_2000;
    rf[8]  = 32'hDEAD_BEEF;
    rf[9]  = 32'h0000_3000;
    rf[12] = 32'h0000_4000;
    rf[20] = 32'h0000_5000;
    rf[30] = 32'h0000_6000;
    idle();
    set_disp(OP_LOAD, 32'h0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 6'd0);
    agu_if.disp_valid = 1'b0;
    rst_n = 1'b0;

    // Reset state
    #12;
    chk("rst_addr_valid", 32'(agu_if.addr_valid), 32'd0);
    chk("rst_addr", agu_if.addr, 32'd0);
    chk("rst_full", 32'(agu_if.full), 32'd0);
    chk("rst_rf_ps1", 32'(agu_if.rf_ps1), 32'd0);
    chk("rst_rf_ps2", 32'(agu_if.rf_ps2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // 1: ready load
    set_disp(OP_LOAD, 32'h10, 6'd5, 1'b1, 6'd0, 1'b0, 6'd3, 6'd1);
    cyc();
    idle();
    chk("t1_sel_valid", 32'(agu_if.addr_valid), 32'd0);
    chk("t1_rf_ps1", 32'(agu_if.rf_ps1), 32'd5);
    cyc();
    chk_result("t1", 32'h1010, 6'd3, 32'd0, 6'd1);
    cyc();
    chk("t1_pulse_end", 32'(agu_if.addr_valid), 32'd0);
    chk("t1_empty_rf", 32'(agu_if.rf_ps1), 32'd0);

    // 2: store waiting on ps1, woken by CDB
    set_disp(OP_STORE, 32'hFFFF_FFFC, 6'd7, 1'b0, 6'd8, 1'b1, 6'd4, 6'd2);
    cyc();
    idle();
    chk("t2_wait_rf", 32'(agu_if.rf_ps1), 32'd0);
    cyc();
    chk("t2_wait_valid", 32'(agu_if.addr_valid), 32'd0);
    agu_if.cdb_valid = 1'b1;
    agu_if.cdb_pd    = 6'd7;
    cyc();
    idle();
    chk("t2_wake_valid", 32'(agu_if.addr_valid), 32'd0);
    chk("t2_rf_ps1", 32'(agu_if.rf_ps1), 32'd7);
    chk("t2_rf_ps2", 32'(agu_if.rf_ps2), 32'd8);
    cyc();
    chk_result("t2", 32'h0000_1FFC, 6'd4, 32'hDEAD_BEEF, 6'd2);
    cyc();

    // 3: fill, ignored 9th dispatch, drain in order
    for (int i = 0; i < 8; i++) begin
      set_disp(OP_LOAD, 32'(i * 4), 6'd9, 1'b0, 6'd0, 1'b0, 6'(i), 6'(i + 10));
      cyc();
    end
    idle();
    chk("t3_full", 32'(agu_if.full), 32'd1);
    set_disp(OP_LOAD, 32'h100, 6'd5, 1'b1, 6'd0, 1'b0, 6'd63, 6'd63);
    cyc();
    idle();
    chk("t3_full_after_9th", 32'(agu_if.full), 32'd1);
    chk("t3_no_issue", 32'(agu_if.addr_valid), 32'd0);
    agu_if.cdb_valid = 1'b1;
    agu_if.cdb_pd    = 6'd9;
    cyc();
    idle();
    chk("t3_sel_full", 32'(agu_if.full), 32'd1);
    chk("t3_sel_rf", 32'(agu_if.rf_ps1), 32'd9);
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk_result($sformatf("t3_e%0d", k), 32'h3000 + 32'(k * 4), 6'(k), 32'd0, 6'(k + 10));
      if (k == 0) chk("t3_full_drop", 32'(agu_if.full), 32'd0);
    end
    cyc();
    chk("t3_drained", 32'(agu_if.addr_valid), 32'd0);

    // 4: dispatch coincident with matching broadcast
    set_disp(OP_LOAD, 32'h8, 6'd12, 1'b0, 6'd0, 1'b0, 6'd7, 6'd5);
    agu_if.cdb_valid = 1'b1;
    agu_if.cdb_pd    = 6'd12;
    cyc();
    idle();
    chk("t4_sel_rf", 32'(agu_if.rf_ps1), 32'd12);
    chk("t4_sel_valid", 32'(agu_if.addr_valid), 32'd0);
    cyc();
    chk_result("t4", 32'h4008, 6'd7, 32'd0, 6'd5);
    cyc();

    // 5: flush while an entry is selected; dispatch in flush cycle dropped
    set_disp(OP_LOAD, 32'h0, 6'd20, 1'b0, 6'd0, 1'b0, 6'd1, 6'd1);
    cyc();
    set_disp(OP_LOAD, 32'h4, 6'd20, 1'b0, 6'd0, 1'b0, 6'd2, 6'd2);
    cyc();
    idle();
    agu_if.cdb_valid = 1'b1;
    agu_if.cdb_pd    = 6'd20;
    cyc();
    idle();
    chk("t5_sel_rf", 32'(agu_if.rf_ps1), 32'd20);
    agu_if.flush = 1'b1;
    set_disp(OP_LOAD, 32'h0, 6'd5, 1'b1, 6'd0, 1'b0, 6'd9, 6'd9);
    cyc();
    idle();
    chk("t5_valid", 32'(agu_if.addr_valid), 32'd0);
    chk("t5_full", 32'(agu_if.full), 32'd0);
    chk("t5_empty_rf", 32'(agu_if.rf_ps1), 32'd0);
    cyc();
    chk("t5_valid2", 32'(agu_if.addr_valid), 32'd0);

    // 6: async reset mid-stream
    set_disp(OP_LOAD, 32'h1, 6'd5, 1'b1, 6'd0, 1'b0, 6'd11, 6'd21);
    cyc();
    set_disp(OP_STORE, 32'h2, 6'd30, 1'b1, 6'd8, 1'b1, 6'd12, 6'd22);
    cyc();
    idle();
    chk_result("t6_pre", 32'h1001, 6'd11, 32'd0, 6'd21);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(agu_if.addr_valid), 32'd0);
    chk("t6_rst_addr", agu_if.addr, 32'd0);
    chk("t6_rst_idx", 32'(agu_if.mem_idx_out), 32'd0);
    chk("t6_rst_wdata", agu_if.store_wdata, 32'd0);
    chk("t6_rst_rob", 32'(agu_if.rob_num_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("t6_quiet%0d", k), 32'(agu_if.addr_valid), 32'd0);
    end
    chk("t6_empty_rf", 32'(agu_if.rf_ps1), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_agu_station.md
Name: mem_agu_station

Overview:
- Reservation station plus address-generation unit (AGU) for loads and stores. It sits between rename/dispatch and the memory queue.
- Holds dispatched memory ops until their physical source registers are ready, then reads the register file and computes the effective address as rs1 + imm.
- Delivers the address, store data and memory-queue index to the memory queue's adder inputs.

Parameters:
DEPTH, 8, number of station entries (power of two, >= 2)
PREG_W, 6, physical register index width
IDX_W, 6, memory-queue index width
ROB_W, 6, ROB number width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  pipeline flush; drops all entries and in-flight result
disp_valid  in  1  dispatch request
disp_opcode  in  7  RV32I opcode (0000011 load, 0100011 store)
disp_imm  in  32  sign-extended offset
disp_ps1  in  PREG_W  base physical register
disp_ps1_ready  in  1  base already available
disp_ps2  in  PREG_W  store-data physical register (ignored for loads)
disp_ps2_ready  in  1  store data already available
disp_mem_idx  in  IDX_W  memory-queue slot allocated at dispatch
disp_rob_num  in  ROB_W  ROB number of the op
full  out  1  all entries valid; dispatch must not be asserted
cdb_valid  in  1  result broadcast valid
cdb_pd  in  PREG_W  broadcast destination register
rf_ps1  out  PREG_W  register-file read address, port 1
rf_ps2  out  PREG_W  register-file read address, port 2
rf_ps1_data  in  32  combinational read data, port 1
rf_ps2_data  in  32  combinational read data, port 2
addr_valid  out  1  result valid (one-cycle pulse per op)
addr  out  32  effective address
mem_idx_out  out  IDX_W  memory-queue slot of the result
store_wdata  out  32  store data (0 for loads)
rob_num_out  out  ROB_W  ROB number of the result

Behaviour:
Reset
- rst_n low clears all entry valid bits asynchronously.
- Reset values: addr_valid=0, addr=0, mem_idx_out=0, store_wdata=0, rob_num_out=0.
- full=0 and rf_ps1=rf_ps2=0 while the station is empty.
- Reset mid-operation discards any in-flight result; no addr_valid follows reset release.

Entry and readiness
- Entry fields: valid, is_store, imm, ps1, r1, ps2, r2, mem_idx, rob_num.
- Register 0 is always ready: r1 is set if disp_ps1==0; r2 is set if disp_ps2==0 or the op is a load.

Dispatch
- When disp_valid && !full, write into the lowest-index free entry on the clock edge.
- If disp_valid is asserted while full, the request is ignored and no state changes.

Wakeup
- On cdb_valid, every valid entry with ps1==cdb_pd sets r1 and every valid entry with ps2==cdb_pd sets r2. Register 0 never wakes anything.
- An op dispatched in the same cycle as a matching broadcast is also captured as ready.
- A woken entry becomes eligible in the following cycle (selection uses registered bits only).

Select and issue (cycle N)
- Eligible means valid && r1 && r2. Select the lowest-index eligible entry; at most one per cycle.
- rf_ps1/rf_ps2 are driven from the selected entry combinationally.
- The selected entry is freed at the end of cycle N.
- A freed slot is reusable by dispatch from cycle N+1; same-cycle reuse is forbidden.

Result (cycle N+1)
- Registered outputs: addr = rf_ps1_data + imm (mod 2^32, no fault checks), store_wdata = store ? rf_ps2_data : 0, and mem_idx_out/rob_num_out from the entry.
- addr_valid=1 for exactly one cycle per issue. Back-to-back issues produce consecutive pulses.
- The memory queue always accepts, so there is no backpressure.

Full
- full = all DEPTH entries valid (combinational from registered state).
- Issue in cycle N clears full from cycle N+1.

Flush
- Synchronous: all entries are invalidated at the edge.
- addr_valid is 0 in the next cycle, even if an issue occurred in the flush cycle.
- Dispatch and wakeup in the flush cycle are discarded.

Test Plan:
1. Load, ps1=5 ready, imm=0x10, mem_idx=3; rf_ps1_data=0x1000 -> addr_valid one cycle after select, addr=0x1010, mem_idx_out=3, store_wdata=0.
2. Store, ps1=7 not ready, ps2=8 ready; cdb_pd=7 two cycles later; rf data 0x2000/0xDEADBEEF, imm=-4 -> no issue before wakeup; issue in the cycle after the broadcast; addr=0x1FFC, store_wdata=0xDEADBEEF.
3. Fill 8 entries all waiting on ps1=9 -> full=1 and a 9th dispatch is ignored; cdb_pd=9 -> entries issue one per cycle in index order 0..7 with 8 consecutive addr_valid pulses, and full deasserts the cycle after the first issue.
4. Dispatch with ps1=12 in the same cycle as cdb_pd=12 -> the entry is eligible the next cycle and the result appears two cycles after dispatch.
5. Two eligible entries, flush asserted in the cycle one is selected -> addr_valid stays 0; the station is empty and full=0 afterwards.
6. rst_n pulsed low asynchronously mid-stream with addr_valid high -> all outputs go to 0 immediately; no pulses after release until a new dispatch.
